// File: rtl/doorlock_pkg.sv
// ---------------------------------------------------------------------------
// doorlock_pkg
// Shared definitions for the doorlock input front end.
//   NUM_KEYS      : number of conditioned inputs (10 switches + star + sharp)
//   KEY_STAR/SHARP: bit positions of the two buttons in the key vector
//   CODE_STAR/SHARP: key_code values reported for the two buttons
//   cond_state_e  : INIT/RUN state of the conditioner FSM
//   edge_mode_e   : which debounced transitions count as a key event
// ---------------------------------------------------------------------------
package doorlock_pkg;

   localparam int NUM_KEYS  = 12;
   localparam int KEY_STAR  = 10;
   localparam int KEY_SHARP = 11;

   localparam logic [3:0] CODE_STAR  = 4'hA;
   localparam logic [3:0] CODE_SHARP = 4'hB;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } cond_state_e;

   typedef enum logic {
      EDGE_ANY  = 1'b0,  // both debounced transitions are events (slide switches)
      EDGE_RISE = 1'b1   // only the press transition is an event (buttons)
   } edge_mode_e;

   // Map a key-vector index to the code shown on the 7-segment path.
   function automatic logic [3:0] key_code_of(input logic [3:0] idx);
      logic [3:0] code;
      if (idx == 4'(KEY_STAR)) begin
         code = CODE_STAR;
      end else if (idx == 4'(KEY_SHARP)) begin
         code = CODE_SHARP;
      end else begin
         code = idx;
      end
      return code;
   endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// ---------------------------------------------------------------------------
// key_debounce_cell
// One conditioned input: 2-flop synchroniser, optional inversion, debounce
// counter, debounced state flop and a registered event pulse.
//   clk, n_rst  : system clock, synchronous active-low reset
//   raw         : asynchronous raw input
//   active_low  : 1 = input is active-low, inverted after synchronisation
//   edge_mode   : EDGE_ANY = any debounced transition is an event,
//                 EDGE_RISE = only 0->1 is an event
//   load        : while high, deb follows the synchronised value directly and
//                 no events are produced (power-on initialisation)
//   evt         : one-cycle event pulse, one cycle after deb changes
// ---------------------------------------------------------------------------
module key_debounce_cell
   import doorlock_pkg::*;
#(
   parameter int DEB_CNT = 500000,
   parameter int CNT_W   = 19
)
(
   input  logic       clk,
   input  logic       n_rst,
   input  logic       raw,
   input  logic       active_low,
   input  edge_mode_e edge_mode,
   input  logic       load,
   output logic       evt
);

   logic             sync1;
   logic             sync2;
   logic             sync_val;
   logic             deb;
   logic             deb_d;
   logic [CNT_W-1:0] cnt;

   // Inversion sits after the synchroniser so the metastability path is a
   // pure flop-to-flop chain.
   assign sync_val = sync2 ^ active_low;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         deb   <= 1'b0;
         deb_d <= 1'b0;
         cnt   <= '0;
         evt   <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         deb_d <= deb;
         evt   <= 1'b0;
         if (load) begin
            // Loading deb_d alongside deb keeps the first RUN cycle free of
            // a phantom transition.
            deb   <= sync_val;
            deb_d <= sync_val;
            cnt   <= '0;
         end else begin
            if (sync_val == deb) begin
               cnt <= '0;
            end else if (cnt == CNT_W'(DEB_CNT - 1)) begin
               // This increment would reach DEB_CNT: flip and restart, so the
               // counter never wraps.
               deb <= ~deb;
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            if (edge_mode == EDGE_ANY) begin
               evt <= deb ^ deb_d;
            end else begin
               evt <= deb & ~deb_d;
            end
         end
      end
   end

endmodule

// File: rtl/doorlock_key_conditioner.sv
// ---------------------------------------------------------------------------
// doorlock_key_conditioner
// Front end for doorlock_2modes: conditions 10 slide switches and the star /
// sharp buttons into single-cycle key pulses plus an encoded last-key value.
//   clk, n_rst   : 50 MHz clock, synchronous active-low reset
//   sw_raw[9:0]  : raw slide switches, SW[i] = digit i
//   star_n_raw   : raw star button, active-low
//   sharp_n_raw  : raw sharp button, active-low
//   number[9:0]  : one-hot digit pulse, 1 cycle
//   star, sharp  : button press pulses, 1 cycle
//   key_code     : last accepted key (0-9, A = star, B = sharp), held
//   key_valid    : 1-cycle strobe, high exactly when number/star/sharp pulse;
//                  key_code is valid in that same cycle (no back-pressure)
//   multi_err    : 1-cycle pulse when two or more events collide
//   state_dbg    : current INIT/RUN state
// ---------------------------------------------------------------------------
module doorlock_key_conditioner
   import doorlock_pkg::*;
#(
   parameter int DEB_CNT = 500000,
   parameter int CNT_W   = 19
)
(
   input  logic        clk,
   input  logic        n_rst,
   input  logic [9:0]  sw_raw,
   input  logic        star_n_raw,
   input  logic        sharp_n_raw,
   output logic [9:0]  number,
   output logic        star,
   output logic        sharp,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        multi_err,
   output cond_state_e state_dbg
);

   // One extra bit so DEB_CNT+1 always fits, whatever CNT_W was chosen.
   localparam int INIT_W = CNT_W + 1;

   cond_state_e         state;
   logic [INIT_W-1:0]   init_cnt;
   logic [NUM_KEYS-1:0] raw_vec;
   logic [NUM_KEYS-1:0] evt;
   logic                load;
   logic [3:0]          n_evt;
   logic [3:0]          evt_idx;

   assign raw_vec   = {sharp_n_raw, star_n_raw, sw_raw};
   assign load      = (state == ST_INIT);
   assign state_dbg = state;

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_cell
      key_debounce_cell #(
         .DEB_CNT (DEB_CNT),
         .CNT_W   (CNT_W)
      ) u_cell (
         .clk        (clk),
         .n_rst      (n_rst),
         .raw        (raw_vec[i]),
         .active_low ((i >= KEY_STAR) ? 1'b1 : 1'b0),
         .edge_mode  ((i >= KEY_STAR) ? EDGE_RISE : EDGE_ANY),
         .load       (load),
         .evt        (evt[i])
      );
   end

   // Event count and index of the (last) active event; the index is only
   // used when the count is exactly one.
   always_comb begin
      n_evt   = '0;
      evt_idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (evt[i]) begin
            n_evt   = n_evt + 4'd1;
            evt_idx = 4'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state     <= ST_INIT;
         init_cnt  <= '0;
         number    <= '0;
         star      <= 1'b0;
         sharp     <= 1'b0;
         key_code  <= '0;
         key_valid <= 1'b0;
         multi_err <= 1'b0;
      end else begin
         number    <= '0;
         star      <= 1'b0;
         sharp     <= 1'b0;
         key_valid <= 1'b0;
         multi_err <= 1'b0;
         case (state)
            ST_INIT: begin
               // DEB_CNT+2 cycles: enough for the synchroniser to fill and
               // for deb to settle on the power-on switch positions.
               if (init_cnt == INIT_W'(DEB_CNT + 1)) begin
                  state <= ST_RUN;
               end else begin
                  init_cnt <= init_cnt + INIT_W'(1);
               end
            end
            ST_RUN: begin
               if (n_evt == 4'd1) begin
                  number    <= evt[9:0];
                  star      <= evt[KEY_STAR];
                  sharp     <= evt[KEY_SHARP];
                  key_valid <= 1'b1;
                  key_code  <= key_code_of(evt_idx);
               end else if (n_evt > 4'd1) begin
                  // Ambiguous input: drop every key and flag it.
                  multi_err <= 1'b1;
               end
            end
            default: state <= ST_INIT;
         endcase
      end
   end

endmodule
